// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake and payload bundle for fetch_queue.
// The master side is the fetch stage and the slave side is the queue itself.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   i_push;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [ADDR_WIDTH-1:0]  i_pc;
  logic [ADDR_WIDTH-1:0]  i_pc_plus4;
  logic [ADDR_WIDTH-1:0]  i_pc_target_pred;
  logic [1:0]             i_btb_way;
  logic                   i_branch_pred_taken;
  logic                   i_stall_dec;
  logic                   i_flush_dec;

  logic                   o_ready;
  logic                   o_valid;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0]  o_pc;
  logic [ADDR_WIDTH-1:0]  o_pc_plus4;
  logic [ADDR_WIDTH-1:0]  o_pc_target_pred;
  logic [1:0]             o_btb_way;
  logic                   o_branch_pred_taken;
  logic [CNT_W-1:0]       o_count;

  modport master (
    output i_push, i_instr, i_pc, i_pc_plus4, i_pc_target_pred, i_btb_way,
           i_branch_pred_taken, i_stall_dec, i_flush_dec,
    input  o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_pc_target_pred,
           o_btb_way, o_branch_pred_taken, o_count
  );

  modport slave (
    input  i_push, i_instr, i_pc, i_pc_plus4, i_pc_target_pred, i_btb_way,
           i_branch_pred_taken, i_stall_dec, i_flush_dec,
    output o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_pc_target_pred,
           o_btb_way, o_branch_pred_taken, o_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue between the fetch and decode stages, with flush and stall.
// Define FETCH_QUEUE_BYPASS_EN to let a push into an empty queue reach decode in the same cycle.
module fetch_queue #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic          i_clk,
  input  logic          i_arst,
  fetch_queue_if.slave  q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  pc_target_pred;
    logic [1:0]             btb_way;
    logic                   branch_pred_taken;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t in_entry;
  entry_t head_entry;
  entry_t out_entry;
  logic   empty;
  logic   ready;
  logic   valid;
  logic   bypass;
  logic   push;
  logic   pop;
  logic   wr_en;
  logic   rd_adv;

  assign in_entry = '{
    instr:             q_if.i_instr,
    pc:                q_if.i_pc,
    pc_plus4:          q_if.i_pc_plus4,
    pc_target_pred:    q_if.i_pc_target_pred,
    btb_way:           q_if.i_btb_way,
    branch_pred_taken: q_if.i_branch_pred_taken
  };

  assign empty = (count_q == '0);
  assign ready = (count_q < CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass     = empty & q_if.i_push & ~q_if.i_flush_dec;
  assign head_entry = bypass ? in_entry : mem_q[rd_ptr_q];
`else
  // Head is taken only from storage so no input-to-output path exists.
  assign bypass     = 1'b0;
  assign head_entry = mem_q[rd_ptr_q];
`endif

  assign valid = ~empty | bypass;
  assign push  = q_if.i_push & ready & ~q_if.i_flush_dec;
  assign pop   = valid & ~q_if.i_stall_dec & ~q_if.i_flush_dec;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en  = push & ~(bypass & pop);
  assign rd_adv = pop & ~bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_if.i_flush_dec) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_arst) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign out_entry = valid ? head_entry : '0;

  assign q_if.o_ready             = ready;
  assign q_if.o_valid             = valid;
  assign q_if.o_count             = count_q;
  assign q_if.o_instr             = out_entry.instr;
  assign q_if.o_pc                = out_entry.pc;
  assign q_if.o_pc_plus4          = out_entry.pc_plus4;
  assign q_if.o_pc_target_pred    = out_entry.pc_target_pred;
  assign q_if.o_btb_way           = out_entry.btb_way;
  assign q_if.o_branch_pred_taken = out_entry.branch_pred_taken;
endmodule
